// File: rtl/neuron_weight_loader_if.sv
// Host-to-loader weight stream: valid/ready handshake with data and end-of-load marker.
interface neuron_weight_loader_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/neuron_weight_loader.sv
// Streams a weight set into the output neuron, then pulses en on request and captures its score.
module neuron_weight_loader #(
    parameter int DATA_W    = 16,
    parameter int N_WEIGHTS = 3,
    parameter int ADDR_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    neuron_weight_loader_if.slave  host,
    input  logic                   start,
    input  logic                   reload,
    output logic                   wen,
    output logic [ADDR_W-1:0]      weight_addr,
    output logic [DATA_W-1:0]      weight_in,
    output logic                   en,
    input  logic [DATA_W-1:0]      score_in,
    output logic [DATA_W-1:0]      score_out,
    output logic                   score_valid,
    output logic                   load_done,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_LOADED, S_RUN, S_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] count, count_nx;
    logic              wr_nx;
    logic              err_set;
    logic              beat;

    // Control outputs are pure state decodes so a reset drops them without waiting for a clock.
    assign host.s_ready = (state inside {S_IDLE, S_LOAD, S_DRAIN});
    assign beat         = host.s_valid && host.s_ready;
    assign en           = (state == S_RUN);
    assign busy         = (state inside {S_RUN, S_WAIT});
    assign load_done    = (state == S_LOADED);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx = state;
        count_nx = count;
        wr_nx    = 1'b0;
        err_set  = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (beat) begin
                    wr_nx = 1'b1;
                    if (count == LAST_IDX) begin
                        count_nx = '0;
                        if (host.s_last) begin
                            state_nx = S_LOADED;
                        end else begin
                            state_nx = S_DRAIN;
                            err_set  = 1'b1;
                        end
                    end else if (host.s_last) begin
                        count_nx = '0;
                        state_nx = S_IDLE;
                        err_set  = 1'b1;
                    end else begin
                        count_nx = count + 1'b1;
                        state_nx = S_LOAD;
                    end
                end
            end
            // Overlong load: swallow the remainder of the frame without writing.
            S_DRAIN:  if (beat && host.s_last) state_nx = S_IDLE;
            S_LOADED: begin
                if (reload)     state_nx = S_IDLE;
                else if (start) state_nx = S_RUN;
            end
            S_RUN:    state_nx = S_WAIT;
            S_WAIT:   state_nx = S_LOADED;
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen         <= 1'b0;
            weight_addr <= '0;
            weight_in   <= '0;
            score_out   <= '0;
            score_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            wen <= wr_nx;
            if (wr_nx) begin
                weight_addr <= count;
                weight_in   <= host.s_data;
            end
            // The neuron presents its score during WAIT; publish it one cycle later.
            if (state == S_WAIT) score_out <= score_in;
            score_valid <= (state == S_WAIT);
            err         <= err | err_set;
        end
    end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Directed bench for neuron_weight_loader with a small behavioural output-neuron model.
module tb_neuron_weight_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              reload = 1'b0;
    logic              wen, en, score_valid, load_done, busy, err;
    logic [ADDR_W-1:0] weight_addr;
    logic [DATA_W-1:0] weight_in, score_in, score_out;

    int checks = 0;
    int errors = 0;

    neuron_weight_loader_if #(.DATA_W(DATA_W)) bus ();

    neuron_weight_loader #(.DATA_W(DATA_W), .N_WEIGHTS(3), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus.slave), .start(start), .reload(reload),
        .wen(wen), .weight_addr(weight_addr), .weight_in(weight_in), .en(en),
        .score_in(score_in), .score_out(score_out), .score_valid(score_valid),
        .load_done(load_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Neuron model: weight RAM, ReLU inputs, score registered on en.
    logic [DATA_W-1:0] wmem [0:3];
    logic [DATA_W-1:0] relu [0:2];
    logic [DATA_W-1:0] score_reg = '0;
    int                wr_cnt [0:3];
    int                wen_total = 0;
    logic              overlap_seen = 1'b0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            wmem[i]   = '0;
            wr_cnt[i] = 0;
        end
    end

    assign score_in = score_reg;

    always @(posedge clk) begin
        if (wen) begin
            wmem[weight_addr]   <= weight_in;
            wr_cnt[weight_addr] <= wr_cnt[weight_addr] + 1;
            wen_total           <= wen_total + 1;
        end
        if (en)
            score_reg <= DATA_W'(wmem[0] * relu[0] + wmem[1] * relu[1] + wmem[2] * relu[2]);
        if (wen && en) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
    endtask

    int snap;

    initial begin
        drive(1'b0, '0, 1'b0);
        relu[0] = 16'd1; relu[1] = 16'd1; relu[2] = 16'd1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_wen", wen, 0);
        check("rst_en", en, 0);
        check("rst_load_done", load_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_score_out", score_out, 0);
        check("rst_score_valid", score_valid, 0);

        // Test 1: clean 3-beat load with back-to-back writes
        drive(1'b1, 16'h0002, 1'b0); tick();
        check("t1_wen0", wen, 1); check("t1_addr0", weight_addr, 0); check("t1_data0", weight_in, 16'h0002);
        drive(1'b1, 16'h0003, 1'b0); tick();
        check("t1_wen1", wen, 1); check("t1_addr1", weight_addr, 1); check("t1_data1", weight_in, 16'h0003);
        check("t1_not_done_yet", load_done, 0);
        drive(1'b1, 16'h0004, 1'b1); tick();
        check("t1_wen2", wen, 1); check("t1_addr2", weight_addr, 2); check("t1_data2", weight_in, 16'h0004);
        check("t1_load_done", load_done, 1); check("t1_s_ready_low", bus.s_ready, 0);
        drive(1'b0, '0, 1'b0); tick();
        check("t1_wen_off", wen, 0); check("t1_done_held", load_done, 1);
        check("t1_wen_total", wen_total, 3); check("t1_err", err, 0);

        // Test 2: one inference, weights 2,3,4 with ReLU 1,1,1 -> 9
        start = 1'b1; tick();
        start = 1'b0;
        check("t2_en_c1", en, 1); check("t2_busy_c1", busy, 1); check("t2_wen_c1", wen, 0);
        tick();
        check("t2_en_c2", en, 0); check("t2_busy_c2", busy, 1); check("t2_sv_c2", score_valid, 0);
        tick();
        check("t2_sv_c3", score_valid, 1); check("t2_score", score_out, 16'h0009);
        check("t2_busy_c3", busy, 0); check("t2_done_c3", load_done, 1);
        tick();
        check("t2_sv_c4", score_valid, 0); check("t2_score_held", score_out, 16'h0009);

        // Test 3: s_last too early
        reload = 1'b1; tick();
        reload = 1'b0;
        check("t3_reload_done", load_done, 0); check("t3_reload_ready", bus.s_ready, 1);
        snap = wr_cnt[2];
        drive(1'b1, 16'h0005, 1'b0); tick();
        check("t3_addr0", weight_addr, 0);
        drive(1'b1, 16'h0006, 1'b1); tick();
        check("t3_wen1", wen, 1); check("t3_addr1", weight_addr, 1);
        check("t3_err", err, 1); check("t3_done", load_done, 0); check("t3_ready", bus.s_ready, 1);
        drive(1'b0, '0, 1'b0); tick(); tick();
        check("t3_no_addr2", wr_cnt[2], snap);

        // Test 4: 5 beats, s_last on the fifth
        snap = wen_total;
        drive(1'b1, 16'h0007, 1'b0); tick();
        check("t4_addr0", weight_addr, 0); check("t4_wen0", wen, 1);
        drive(1'b1, 16'h0008, 1'b0); tick();
        check("t4_addr1", weight_addr, 1);
        drive(1'b1, 16'h0009, 1'b0); tick();
        check("t4_addr2", weight_addr, 2); check("t4_wen2", wen, 1);
        check("t4_err", err, 1); check("t4_drain_ready", bus.s_ready, 1);
        drive(1'b1, 16'h000A, 1'b0); tick();
        check("t4_wen3", wen, 0); check("t4_done3", load_done, 0);
        drive(1'b1, 16'h000B, 1'b1); tick();
        check("t4_wen4", wen, 0);
        drive(1'b0, '0, 1'b0); tick();
        check("t4_wen_total", wen_total - snap, 3); check("t4_ready", bus.s_ready, 1);
        check("t4_done", load_done, 0); check("t4_err_sticky", err, 1);

        // Test 5: start ignored while loading; start+reload in LOADED -> IDLE
        start = 1'b1;
        drive(1'b1, 16'h0001, 1'b0); tick();
        check("t5_addr0_after_drain", weight_addr, 0); check("t5_en0", en, 0);
        drive(1'b1, 16'h0002, 1'b0); tick();
        check("t5_en1", en, 0);
        drive(1'b1, 16'h0003, 1'b1); tick();
        check("t5_en2", en, 0); check("t5_loaded", load_done, 1); check("t5_addr2", weight_addr, 2);
        drive(1'b0, '0, 1'b0);
        reload = 1'b1; tick();
        start = 1'b0; reload = 1'b0;
        check("t5_en_reload", en, 0); check("t5_busy_reload", busy, 0);
        check("t5_done_reload", load_done, 0); check("t5_ready_reload", bus.s_ready, 1);
        tick();
        check("t5_en_after", en, 0);

        // Test 6: reset during RUN, then a normal load and inference
        relu[0] = 16'd2; relu[1] = 16'd1; relu[2] = 16'd3;
        drive(1'b1, 16'h0005, 1'b0); tick();
        drive(1'b1, 16'h0006, 1'b0); tick();
        drive(1'b1, 16'h0007, 1'b1); tick();
        drive(1'b0, '0, 1'b0);
        check("t6_loaded", load_done, 1);
        start = 1'b1; tick();
        start = 1'b0;
        check("t6_en_run", en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", en, 0); check("t6_rst_busy", busy, 0);
        check("t6_rst_sv", score_valid, 0); check("t6_rst_done", load_done, 0);
        check("t6_rst_err", err, 0); check("t6_rst_wen", wen, 0);
        tick();
        rst_n = 1'b1;
        check("t6_ready_after", bus.s_ready, 1);
        drive(1'b1, 16'h0005, 1'b0); tick();
        check("t6_addr0", weight_addr, 0);
        drive(1'b1, 16'h0006, 1'b0); tick();
        drive(1'b1, 16'h0007, 1'b1); tick();
        drive(1'b0, '0, 1'b0);
        check("t6_reloaded", load_done, 1);
        start = 1'b1; tick();
        start = 1'b0;
        tick(); tick();
        check("t6_sv", score_valid, 1); check("t6_score", score_out, 16'h0025);
        check("t6_err_clean", err, 0);

        check("no_wen_en_overlap", overlap_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
